// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two byte-stream requesters share one Wishbone master that writes a UART.
//   After reset the UART divider is written once; with UART_ARB_SANITY_CHECK_EN
//   defined, a sanity register is read next and compared against a magic value.
//   Bytes are then granted round-robin and written to the TX data register.
//
//   Optional feature macro: UART_ARB_SANITY_CHECK_EN (adds the CHECK state).
//
// Ports
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   reqN_valid_i/data_i      requester N byte offer
//   reqN_ready_o             one-cycle grant pulse (byte taken)
//   wb_*_o / wb_*_i          Wishbone master towards the UART
//   init_done_o              set on first IDLE entry, held until reset
//   busy_o                   1 in every state except IDLE
//   sanity_err_o             sanity register mismatch (0 without the macro)
//
// state    | meaning
// INIT_DIV | write DIVIDER_INIT to BASE+0x0, wait for ack
// CHECK    | read BASE+0x8 for 4 cycles, compare on the last (macro only)
// IDLE     | grant a requester, latch its byte
// XFER     | write latched byte to BASE+0x4 until ack
// GAP      | one idle bus cycle so the slave's registered ack drops
module uart_tx_arbiter #(
    parameter int          WB_DATA_WIDTH  = 32,
    parameter int          WB_ADDR_WIDTH  = 32,
    parameter logic [31:0] UART_BASE_ADDR = 32'h0,
    parameter logic [31:0] DIVIDER_INIT   = 32'd1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       req0_valid_i,
    input  logic [7:0]                 req0_data_i,
    output logic                       req0_ready_o,
    input  logic                       req1_valid_i,
    input  logic [7:0]                 req1_data_i,
    output logic                       req1_ready_o,
    output logic [WB_ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
    output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                       wb_we_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    input  logic                       wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
    output logic                       init_done_o,
    output logic                       busy_o,
    output logic                       sanity_err_o
);

    typedef enum logic [2:0] {
        INIT_DIV,
`ifdef UART_ARB_SANITY_CHECK_EN
        CHECK,
`endif
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t                     state_q, state_d;
    logic                       prio_q, prio_d;   // 0: req0 wins a tie
    logic [7:0]                 byte_q, byte_d;
    logic                       init_done_q;
    logic                       cyc_q, cyc_d, we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0]   data_q, data_d;
    logic [WB_DATA_WIDTH/8-1:0] sel_q, sel_d;
    logic                       grant0, grant1;

`ifdef UART_ARB_SANITY_CHECK_EN
    logic [1:0] cnt_q, cnt_d;
    logic       chk_done_q, chk_done_d;
    logic       san_err_q, san_err_d;
`else
    logic       unused_rdata;
    assign unused_rdata = ^wb_data_i;
`endif

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        byte_d  = byte_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
`ifdef UART_ARB_SANITY_CHECK_EN
        cnt_d      = cnt_q;
        chk_done_d = chk_done_q;
        san_err_d  = san_err_q;
`endif
        case (state_q)
            INIT_DIV: begin
                // cyc_q gates the ack: the first cycle after reset has no access out yet
                if (cyc_q && wb_ack_i) state_d = GAP;
            end
`ifdef UART_ARB_SANITY_CHECK_EN
            CHECK: begin
                if (cnt_q == 2'd0) begin
                    san_err_d  = (wb_data_i != WB_DATA_WIDTH'(32'hA17EB0B0));
                    chk_done_d = 1'b1;
                    state_d    = GAP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
`endif
            IDLE: begin
                if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
                    grant0  = 1'b1;
                    byte_d  = req0_data_i;
                    prio_d  = 1'b1;
                    state_d = XFER;
                end else if (req1_valid_i) begin
                    grant1  = 1'b1;
                    byte_d  = req1_data_i;
                    prio_d  = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (wb_ack_i) state_d = GAP;
            end
            GAP: begin
`ifdef UART_ARB_SANITY_CHECK_EN
                if (!chk_done_q) begin
                    state_d = CHECK;
                    cnt_d   = 2'd3;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = INIT_DIV;
        endcase

        // Bus outputs are registered from the next state so reset clears them at once.
        cyc_d  = 1'b0;
        we_d   = 1'b0;
        addr_d = '0;
        data_d = '0;
        sel_d  = '0;
        case (state_d)
            INIT_DIV: begin
                cyc_d  = 1'b1;
                we_d   = 1'b1;
                addr_d = WB_ADDR_WIDTH'(UART_BASE_ADDR);
                data_d = WB_DATA_WIDTH'(DIVIDER_INIT);
                sel_d  = '1;
            end
`ifdef UART_ARB_SANITY_CHECK_EN
            CHECK: begin
                cyc_d  = 1'b1;
                addr_d = WB_ADDR_WIDTH'(UART_BASE_ADDR + 32'h8);
                sel_d  = '1;
            end
`endif
            XFER: begin
                cyc_d  = 1'b1;
                we_d   = 1'b1;
                addr_d = WB_ADDR_WIDTH'(UART_BASE_ADDR + 32'h4);
                data_d = WB_DATA_WIDTH'(byte_d);
                sel_d  = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= INIT_DIV;
            prio_q      <= 1'b0;
            byte_q      <= '0;
            init_done_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            byte_q      <= byte_d;
            init_done_q <= init_done_q | (state_d == IDLE);
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
        end
    end

`ifdef UART_ARB_SANITY_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            chk_done_q <= 1'b0;
            san_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            chk_done_q <= chk_done_d;
            san_err_q  <= san_err_d;
        end
    end
    assign sanity_err_o = san_err_q;
`else
    assign sanity_err_o = 1'b0;
`endif

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign wb_addr_o    = addr_q;
    assign wb_data_o    = data_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign init_done_o  = init_done_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [7:0]  d0 = 8'h0, d1 = 8'h0;
    logic        r0, r1;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        ack;
    logic [31:0] sdata = 32'hA17EB0B0;
    logic        init_done, busy, san_err;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
        .wb_addr_o(addr), .wb_data_o(wdata), .wb_sel_o(sel),
        .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
        .wb_ack_i(ack), .wb_data_i(sdata),
        .init_done_o(init_done), .busy_o(busy), .sanity_err_o(san_err)
    );

    // Slave: registered ack ack_delay cycles after stb on writes; reads never acked.
    int          ack_delay = 2;
    int          scnt;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            scnt <= 0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && we && !ack) begin
                if (scnt >= ack_delay - 1) begin
                    ack  <= 1'b1;
                    scnt <= 0;
                    log_addr.push_back(addr);
                    log_data.push_back(wdata);
                end else begin
                    scnt <= scnt + 1;
                end
            end else begin
                scnt <= 0;
            end
        end
    end

    // Protocol monitor, sampled mid-cycle.
    int          viol_cycstb = 0, viol_ready = 0, viol_stable = 0;
    int          gap_checks = 0, gap_bad = 0, gap_cnt = 0;
    int          rd_run = 0, rd_len_last = 0;
    bit          gap_arm = 0;
    logic        prev_cyc = 0, prev_we = 0, prev_r0 = 0, prev_r1 = 0;
    logic [31:0] prev_addr = 0, prev_data = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            gap_arm  <= 0;
            prev_cyc <= 0;
            prev_r0  <= 0;
            prev_r1  <= 0;
            rd_run   <= 0;
        end else begin
            if (cyc !== stb) viol_cycstb <= viol_cycstb + 1;
            if (((r0 || r1) && busy) || (r0 && r1) || (r0 && prev_r0) || (r1 && prev_r1))
                viol_ready <= viol_ready + 1;
            if (prev_cyc && cyc && (wdata !== prev_data || addr !== prev_addr || we !== prev_we))
                viol_stable <= viol_stable + 1;
            if (gap_arm) begin
                if (!cyc && busy) gap_cnt <= gap_cnt + 1;
                else begin
                    gap_checks <= gap_checks + 1;
                    if (gap_cnt != 1) gap_bad <= gap_bad + 1;
                    gap_arm <= 0;
                end
            end
            if (ack && cyc) begin
                gap_arm <= 1;
                gap_cnt <= 0;
            end
            if (cyc && !we) rd_run <= rd_run + 1;
            else if (rd_run != 0) begin
                rd_len_last <= rd_run;
                rd_run      <= 0;
            end
            prev_cyc  <= cyc;
            prev_we   <= we;
            prev_addr <= addr;
            prev_data <= wdata;
            prev_r0   <= r0;
            prev_r1   <= r1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] log_d(input int i);
        if (i < log_data.size()) return log_data[i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] log_a(input int i);
        if (i < log_addr.size()) return log_addr[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic wait_init(input string nm);
        int n = 0;
        while (!init_done && n < 60) begin tick(); n++; end
        chk(nm, {31'd0, init_done}, 32'd1);
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (log_data.size() < n && c < budget) begin tick(); c++; end
        if (log_data.size() < n) chk("write_timeout", log_data.size(), n);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 50) begin tick(); c++; end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Offer bytes, return who got the grant (-1 on timeout), drop valids afterwards.
    task automatic grant_one(input bit a0, input logic [7:0] x0, input bit a1,
                             input logic [7:0] x1, output int who);
        who = -1;
        v0 = a0; d0 = x0; v1 = a1; d1 = x1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (r0) begin who = 0; break; end
            if (r1) begin who = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
    endtask

    task automatic do_reset(input logic [31:0] magic);
        rst_n = 0; v0 = 0; v1 = 0;
        repeat (3) tick();
        log_addr.delete();
        log_data.delete();
        ack_delay = 2;
        sdata = magic;
        rst_n = 1;
    endtask

    typedef struct {
        bit         a0;
        logic [7:0] x0;
        bit         a1;
        logic [7:0] x1;
        int         dly;
        int         exp_who;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];
    int   who, base, n;
    int   gcyc[4];
    int   gwho[4];
    int   hold_bad;

    initial begin
        // Round-robin expectations traced by hand; priority starts at req0.
        vecs[0] = '{1, 8'h41, 0, 8'h00, 2, 0, 8'h41};
        vecs[1] = '{0, 8'h00, 1, 8'h52, 2, 1, 8'h52};
        vecs[2] = '{1, 8'h10, 1, 8'h11, 2, 0, 8'h10};
        vecs[3] = '{1, 8'h20, 1, 8'h21, 3, 1, 8'h21};
        vecs[4] = '{0, 8'h00, 1, 8'h33, 1, 1, 8'h33};
        vecs[5] = '{1, 8'h44, 1, 8'h45, 2, 0, 8'h44};
        vecs[6] = '{1, 8'hFF, 0, 8'h00, 5, 0, 8'hFF};
        vecs[7] = '{1, 8'h00, 1, 8'h80, 2, 1, 8'h80};

        #1;
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_ready", {30'd0, r0, r1}, 0);
        chk("rst_init_done", {31'd0, init_done}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_sanity", {31'd0, san_err}, 0);
        repeat (3) tick();
        rst_n = 1;

        wait_init("init_done");
        chk("init_writes", log_data.size(), 1);
        chk("init_addr", log_a(0), 32'h0);
        chk("init_data", log_d(0), 32'h1);
`ifdef UART_ARB_SANITY_CHECK_EN
        chk("check_len", rd_len_last, 4);
        chk("sanity_ok", {31'd0, san_err}, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            ack_delay = vecs[i].dly;
            base = log_data.size();
            grant_one(vecs[i].a0, vecs[i].x0, vecs[i].a1, vecs[i].x1, who);
            chk($sformatf("vec%0d_who", i), who, vecs[i].exp_who);
            wait_log(base + 1, 40);
            chk($sformatf("vec%0d_addr", i), log_a(base), 32'h4);
            chk($sformatf("vec%0d_data", i), log_d(base), {24'h0, vecs[i].exp_byte});
            wait_idle();
        end

        // Both continuously valid: alternation and grant spacing 1 + 3 + 1.
        ack_delay = 2;
        base = log_data.size();
        v0 = 1; d0 = 8'h30; v1 = 1; d1 = 8'h31;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            #1;
            if (r0 || r1) begin gcyc[n] = c; gwho[n] = r1 ? 1 : 0; n++; end
            @(posedge clk); #1;
        end
        v0 = 0; v1 = 0;
        chk("alt_grants", n, 4);
        wait_log(base + 4, 40);
        for (int k = 0; k < 4; k++)
            chk($sformatf("alt_byte%0d", k), log_d(base + k), (k % 2 == 0) ? 32'h30 : 32'h31);
        chk("alt_spacing", gcyc[3] - gcyc[2], 5);
        wait_idle();

        // Ack held off ~1000 cycles; req1 arrives meanwhile and must wait.
        ack_delay = 1000;
        base = log_data.size();
        grant_one(1, 8'h5A, 0, 8'h00, who);
        chk("hold_who", who, 0);
        v1 = 1; d1 = 8'h5B;
        hold_bad = 0;
        for (int c = 0; c < 990; c++) begin
            if (wdata !== 32'h5A || !cyc || r0 || r1) hold_bad++;
            tick();
        end
        chk("hold_stable", hold_bad, 0);
        wait_log(base + 1, 60);
        ack_delay = 2;
        chk("hold_byte", log_d(base), 32'h5A);
        grant_one(1'b0, 8'h00, 1'b1, 8'h5B, who);
        chk("wait_who", who, 1);
        wait_log(base + 2, 40);
        chk("wait_byte", log_d(base + 1), 32'h5B);
        wait_idle();

        // Reset three cycles into XFER of 0x42.
        ack_delay = 1000;
        grant_one(1, 8'h42, 0, 8'h00, who);
        tick(); tick();
        #2;
        rst_n = 0;
        #1;
        chk("abort_cyc", {31'd0, cyc}, 0);
        chk("abort_stb", {31'd0, stb}, 0);
        chk("abort_addr", addr, 0);
        chk("abort_init_done", {31'd0, init_done}, 0);
        do_reset(32'hA17EB0B0);
        wait_init("reinit_done");
        chk("reinit_addr", log_a(0), 32'h0);
        chk("reinit_data", log_d(0), 32'h1);
        repeat (20) tick();
        chk("no_resend", log_data.size(), 1);

`ifdef UART_ARB_SANITY_CHECK_EN
        do_reset(32'hDEADBEEF);
        wait_init("bad_init_done");
        chk("sanity_err", {31'd0, san_err}, 1);
        base = log_data.size();
        grant_one(1, 8'h55, 0, 8'h00, who);
        wait_log(base + 1, 40);
        chk("after_err_byte", log_d(base), 32'h55);
`else
        chk("sanity_tied", {31'd0, san_err}, 0);
`endif

        repeat (3) tick();
        chk("cyc_eq_stb", viol_cycstb, 0);
        chk("ready_rules", viol_ready, 0);
        chk("bus_stable", viol_stable, 0);
        chk("gap_len", gap_bad, 0);
        chk("gap_seen", {31'd0, gap_checks > 0}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
